button_sync_debounce: RTL
=========================

Name: button_sync_debounce

Overview:
Parametrised successor to the keypad synchronizer: brings a WIDTH-bit asynchronous button vector into the clock domain through a configurable flop chain, debounces the whole vector, and emits one-cycle press/release pulses. Adds optional auto-repeat while a key is held, plus encoded key index and multi-key flag. Sits between the board push-buttons and the musical-calculator input decoder.

Parameters:
WIDTH, 8, number of button channels (>=1)
SYNC_STAGES, 2, synchronizer flop depth (>=2)
DEBOUNCE_CYCLES, 4, consecutive identical synchronized samples required to accept a new vector (>=1)
REPEAT_CYCLES, 0, auto-repeat period in clocks while held; 0 disables repeat

Ports:
clock  input  1  system clock, rising edge
resetN  input  1  asynchronous, active-low reset
Button  input  WIDTH  raw asynchronous buttons, 1 = pressed
Stable  output  WIDTH  debounced button vector
Push  output  1  one-cycle pulse: new non-zero Stable accepted, or repeat tick
Release  output  1  one-cycle pulse: Stable went non-zero -> zero
KeyIndex  output  max(1,$clog2(WIDTH))  index of lowest set bit of Stable; 0 when Stable is zero
MultiKey  output  1  high while Stable has more than one bit set

Behaviour:
- Reset (resetN low, asynchronous): sync chain, candidate, debounce counter, repeat counter, Stable, Push, Release, KeyIndex, MultiKey all 0. Takes effect immediately, mid-debounce or mid-repeat; no pulse is emitted on reset entry or exit.
- Sync: Button passes through SYNC_STAGES flops. Synchronized vector s is the last stage.
- Debounce, per edge:
  - s != candidate: candidate <= s, cnt <= 0.
  - s == candidate and cnt < DEBOUNCE_CYCLES-1: cnt++.
  - s == candidate, cnt == DEBOUNCE_CYCLES-1, candidate != Stable: Stable <= candidate (cnt holds).
- Latency: with Button constant from sampling edge 1, Stable updates on edge SYNC_STAGES+DEBOUNCE_CYCLES+1 (edge 7 at defaults). Any synchronized glitch shorter than DEBOUNCE_CYCLES cycles never reaches Stable.
- Pulses, registered, aligned with the Stable update edge, high exactly one cycle:
  - Stable zero -> non-zero: Push.
  - Stable non-zero A -> non-zero B (A != B): Push only, no Release.
  - Stable non-zero -> zero: Release only.
  - Push and Release are never high in the same cycle.
- Auto-repeat (REPEAT_CYCLES > 0):
  - Repeat counter clears on every Stable change and on every Push.
  - While Stable is non-zero and unchanged, it increments each edge.
  - When it reaches REPEAT_CYCLES it pulses Push and clears, so repeat Push pulses are REPEAT_CYCLES edges apart.
  - A Stable change in the same cycle as a repeat tick takes priority: the counter clears, and Push/Release follow the change rules above.
  - REPEAT_CYCLES = 0: no repeat logic; exactly one Push per accepted press.
- KeyIndex and MultiKey: combinational from Stable (no extra latency). Lowest set bit wins.

Test Plan:
- Reset then Button=8'b10001000 held 20 clocks (100 ns period, change at negedge) -> Stable=8'b10001000 on 7th rising edge after change; Push high exactly one cycle; KeyIndex=3; MultiKey=1; Release stays 0.
- Button 8'b00000100 for 2 cycles, then 0 -> Stable stays 0; Push and Release never assert.
- Button 8'b01001000 held, then switched to 8'b00101000 -> second Push 7 edges after switch, Release stays 0; KeyIndex=3 both times; then Button=0 -> Release one cycle 7 edges later, Stable=0, KeyIndex=0, MultiKey=0.
- REPEAT_CYCLES=10, Button 8'b00010000 held 40 clocks -> Push at accept edge, then every 10 edges (4 pulses total); KeyIndex=4; MultiKey=0.
- resetN pulled low 3 edges into debounce of 8'b10000100 and released with Button still held -> all outputs 0 immediately; Push appears 7 edges after the first post-reset edge, with no spurious Release.
- WIDTH=1, SYNC_STAGES=3, DEBOUNCE_CYCLES=1 -> Stable follows a clean press on edge 5; KeyIndex width 1, constant 0.

Source files
------------

// File: rtl/button_sync_debounce_if.sv
// rtl/button_sync_debounce_if.sv - button vector in, debounced key state and pulses out
//
// Button   : raw asynchronous buttons, 1 = pressed (driven by master)
// Stable   : debounced button vector
// Push     : one-cycle pulse on new non-zero vector or repeat tick
// Release  : one-cycle pulse when the vector returns to zero
// KeyIndex : index of lowest set bit of Stable, 0 when Stable is zero
// MultiKey : Stable has more than one bit set
interface button_sync_debounce_if #(
    parameter int WIDTH = 8
);
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] Button;
    logic [WIDTH-1:0] Stable;
    logic             Push;
    logic             Release;
    logic [KW-1:0]    KeyIndex;
    logic             MultiKey;

    modport master (
        output Button,
        input  Stable,
        input  Push,
        input  Release,
        input  KeyIndex,
        input  MultiKey
    );

    modport slave (
        input  Button,
        output Stable,
        output Push,
        output Release,
        output KeyIndex,
        output MultiKey
    );
endinterface

// File: rtl/button_sync_debounce.sv
// rtl/button_sync_debounce.sv - synchronize, debounce and pulse-encode a button vector
//
// clock  : system clock, rising edge
// resetN : asynchronous active-low reset
// bus    : button_sync_debounce_if slave (Button in; Stable, Push, Release,
//          KeyIndex, MultiKey out)
module button_sync_debounce #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic                    clock,
    input  logic                    resetN,
    button_sync_debounce_if.slave   bus
);
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] cand_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] stable_q;
    logic             push_q;
    logic             release_q;
    logic             accept;
    logic             repeat_tick;
    logic [KW-1:0]    key_index;
    logic             multi_key;

    // Synchronizer chain; s is the last stage.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.Button;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Candidate tracks the synchronized vector; the counter saturates once
    // the candidate has been seen DEBOUNCE_CYCLES times in a row.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            cand_q <= '0;
            cnt_q  <= '0;
        end else if (s != cand_q) begin
            cand_q <= s;
            cnt_q  <= '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign accept = (s == cand_q) && (cnt_q == CNT_LAST) && (cand_q != stable_q);

    // Stable register and registered pulses. An accepted change always wins
    // over a repeat tick in the same cycle.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            stable_q  <= '0;
            push_q    <= 1'b0;
            release_q <= 1'b0;
        end else begin
            push_q    <= 1'b0;
            release_q <= 1'b0;
            if (accept) begin
                stable_q  <= cand_q;
                push_q    <= |cand_q;
                release_q <= ~|cand_q;
            end else if (repeat_tick) begin
                push_q <= 1'b1;
            end
        end
    end

    generate
        if (REPEAT_CYCLES > 0) begin : g_repeat
            localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
            localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

            logic [RW-1:0] rep_q;

            // Counts 0..REPEAT_CYCLES-1 while a non-zero vector is held; the
            // tick on the last value gives pulses REPEAT_CYCLES edges apart.
            always_ff @(posedge clock or negedge resetN) begin
                if (!resetN) begin
                    rep_q <= '0;
                end else if (accept || (stable_q == '0) || (rep_q == REP_LAST)) begin
                    rep_q <= '0;
                end else begin
                    rep_q <= rep_q + 1'b1;
                end
            end

            assign repeat_tick = !accept && (stable_q != '0) && (rep_q == REP_LAST);
        end else begin : g_no_repeat
            assign repeat_tick = 1'b0;
        end
    endgenerate

    // Lowest set bit wins: scan from the top so the last hit is the lowest.
    always_comb begin
        key_index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (stable_q[i]) begin
                key_index = KW'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_key = |(stable_q & (stable_q - WIDTH'(1)));

    assign bus.Stable   = stable_q;
    assign bus.Push     = push_q;
    assign bus.Release  = release_q;
    assign bus.KeyIndex = key_index;
    assign bus.MultiKey = multi_key;
endmodule
